// File: rtl/cm_pkg.sv
// Shared types for the CM pixel responder: FSM states, pixel-op encodings
// and the sideband bundle that travels down the pipeline with each pixel.
package cm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_INV  = 2'b01;
  localparam logic [1:0] OP_THR  = 2'b10;
  localparam logic [1:0] OP_BRT  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       enb;
    logic       wea1;
    logic       wea2;
    logic [1:0] sel;
  } stage_t;

endpackage

// File: rtl/cm_pixel_op.sv
// Combinational per-pixel operator: pass, invert, threshold or saturating
// brighten, selected by the 2-bit op code carried with the pixel.
module cm_pixel_op
  import cm_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int THRESH = 128,
  parameter int BRIGHT = 32
) (
  input  logic [1:0]       sel_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] pix_o
);

  localparam logic [PIX_W-1:0] THR_V = PIX_W'(THRESH);
  localparam logic [PIX_W:0]   BRT_V = (PIX_W + 1)'(BRIGHT);

  // One extra bit so the carry out tells us when to saturate.
  logic [PIX_W:0] sum_wide;
  assign sum_wide = {1'b0, pix_i} + BRT_V;

  always_comb begin
    pix_o = pix_i;
    case (sel_i)
      OP_PASS: pix_o = pix_i;
      OP_INV:  pix_o = ~pix_i;
      OP_THR:  pix_o = (pix_i >= THR_V) ? '1 : '0;
      OP_BRT:  pix_o = sum_wide[PIX_W] ? '1 : sum_wide[PIX_W-1:0];
      default: pix_o = pix_i;
    endcase
  end

endmodule

// File: rtl/cm_pixel_responder.sv
// Datapath responder to the CM controller: issues source reads, applies the
// pixel op two stages later, writes to one or both destination banks.
module cm_pixel_responder
  import cm_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int PIX_W   = 8,
  parameter int NUM_PIX = 65536,
  parameter int THRESH  = 128,
  parameter int BRIGHT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              enb,
  input  logic              wea1,
  input  logic              wea2,
  input  logic [1:0]        sel,
  input  logic              complete,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_dout,
  output logic              dst_we1,
  output logic              dst_we2,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_din,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  stage_t            s1_q, s1_d, s2_q;
  logic [PIX_W-1:0]  op_res;
  logic [PIX_W-1:0]  pix2_q;
  logic              busy_q, done_q;
  logic              rd_ok, rd_fire, wr1, wr2;

  // Reads are only accepted before the frame starts draining; reset gates
  // the strobe so the outputs are quiet the moment rst_n drops.
  assign rd_ok   = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign rd_fire = rst_n & ena & rd_ok;
  assign wr1     = s2_q.valid & s2_q.enb & s2_q.wea1;
  assign wr2     = s2_q.valid & s2_q.enb & s2_q.wea2;

  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (complete)  state_d = ST_DRAIN;
        else if (ena)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (complete)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Two drain cycles cover the read-to-write latency.
        drain_d = ~drain_q;
        if (drain_q)   state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    if (state_q == ST_DONE) begin
      src_addr_d = '0;
      dst_addr_d = '0;
    end else begin
      if (rd_fire)    src_addr_d = next_addr(src_addr_q);
      if (wr1 | wr2)  dst_addr_d = next_addr(dst_addr_q);
    end
  end

  always_comb begin
    s1_d       = '0;
    s1_d.valid = rd_fire;
    s1_d.enb   = enb;
    s1_d.wea1  = wea1;
    s1_d.wea2  = wea2;
    s1_d.sel   = sel;
  end

  cm_pixel_op #(
    .PIX_W  (PIX_W),
    .THRESH (THRESH),
    .BRIGHT (BRIGHT)
  ) u_op (
    .sel_i (s1_q.sel),
    .pix_i (src_dout),
    .pix_o (op_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      drain_q    <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      pix2_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      s1_q       <= s1_d;
      s2_q       <= s1_q;
      pix2_q     <= op_res;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign src_en   = rd_fire;
  assign src_addr = src_addr_q;
  assign dst_we1  = wr1;
  assign dst_we2  = wr2;
  assign dst_addr = dst_addr_q;
  assign dst_din  = pix2_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
